// File: rtl/mac_stream_driver_if.sv
// Bundle of the weight-write port, the activation/result valid-ready streams and the MAC control pins.
// No logic of its own: it only carries signals between the driver and its environment.
// master = the driver (mac_stream_driver); slave = the upstream/downstream/MAC side.
interface mac_stream_driver_if #(
    parameter int N      = 8,
    parameter int ADDR_W = 4
);
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [N-1:0]      w_wr_data;
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_data;
    logic [N-1:0]      mac_weight;
    logic [N-1:0]      mac_in;
    logic              mac_reset;
    logic              mac_oe;
    logic              mac_forget;
    logic [N-1:0]      mac_out;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_data;

    modport master (
        input  w_wr_en, w_wr_addr, w_wr_data,
        input  in_valid, in_data,
        output in_ready,
        output mac_weight, mac_in, mac_reset, mac_oe, mac_forget,
        input  mac_out,
        output out_valid, out_data,
        input  out_ready
    );

    modport slave (
        output w_wr_en, w_wr_addr, w_wr_data,
        output in_valid, in_data,
        input  in_ready,
        input  mac_weight, mac_in, mac_reset, mac_oe, mac_forget,
        output mac_out,
        input  out_valid, out_data,
        output out_ready
    );
endinterface

// File: rtl/mac_stream_driver.sv
// Feeds one activation vector (paired with stored weights) into a MAC, drains it, captures the result.
// Latency: result valid 3 cycles after the last element handshake; new vector costs IDLE+CLEAR.
// Backpressure: in_ready only in STREAM; a result waits in HOLD until out_ready, blocking new vectors.
module mac_stream_driver #(
    parameter int N        = 8,
    parameter int N_INPUTS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    mac_stream_driver_if.master bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_STREAM  = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_HOLD    = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [N-1:0]      out_data_q;
    logic [N-1:0]      wram [N_INPUTS];

    logic hs;
    logic last;
    logic addr_ok;

    // An element is consumed only in STREAM; reset masks everything so outputs show reset values.
    assign hs      = (state == S_STREAM) & bus.in_valid & ~reset;
    assign last    = (cnt == ADDR_W'(N_INPUTS - 1));
    assign addr_ok = (32'(bus.w_wr_addr) < 32'(N_INPUTS));

    assign bus.in_ready   = (state == S_STREAM) & ~reset;
    assign bus.mac_reset  = reset | (state == S_CLEAR);
    assign bus.mac_oe     = (state == S_CAPTURE) & ~reset;
    assign bus.mac_forget = 1'b0;
    // Bubbles drive zeros so the MAC accumulates nothing on idle cycles.
    assign bus.mac_in     = hs ? bus.in_data : '0;
    assign bus.mac_weight = hs ? wram[cnt] : '0;
    assign bus.out_valid  = (state == S_HOLD) & ~reset;
    assign bus.out_data   = out_data_q;

    // Next-state selection for the vector sequencing FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (bus.in_valid) state_nxt = S_CLEAR;
            S_CLEAR:   state_nxt = S_STREAM;
            S_STREAM:  if (hs && last) state_nxt = S_DRAIN;
            S_DRAIN:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_HOLD;
            S_HOLD:    if (bus.out_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // State, element counter and captured result; reset aborts any vector in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            out_data_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) begin
                cnt <= '0;
            end else if (hs) begin
                cnt <= last ? '0 : cnt + ADDR_W'(1);
            end
            if (state == S_CAPTURE) begin
                out_data_q <= bus.mac_out;
            end
        end
    end

    // Weight RAM: unreset so weights survive reset; written only while idle with a legal index.
    always_ff @(posedge clk) begin
        if (!reset && state == S_IDLE && bus.w_wr_en && addr_ok) begin
            wram[bus.w_wr_addr] <= bus.w_wr_data;
        end
    end

endmodule

// File: tb/tb_mac_stream_driver.sv
// Directed bench for mac_stream_driver with a behavioural MAC stub (out = accumulator[N-1:0]).
// Expected results are pushed per vector from a weight/sum model and popped on each result handshake.
module tb_mac_stream_driver;
    localparam int N  = 8;
    localparam int NI = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_stream_driver_if #(.N(N), .ADDR_W(AW)) bus();

    mac_stream_driver #(.N(N), .N_INPUTS(NI), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mrst_cnt = 0;
    int results = 0;
    int last_hs = 0;
    int idx = 0;
    logic [7:0] sum;
    logic [7:0] wmodel [NI];
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // MAC stub: inputs latched at end of cycle t, accumulated at end of t+1.
    logic [7:0]  lat_w, lat_in;
    logic [31:0] acc;
    always @(posedge clk) begin
        if (bus.mac_reset) begin
            lat_w  <= 8'd0;
            lat_in <= 8'd0;
            acc    <= 32'd0;
        end else begin
            lat_w  <= bus.mac_weight;
            lat_in <= bus.mac_in;
            acc    <= acc + 32'(lat_w) * 32'(lat_in);
        end
    end
    assign bus.mac_out = bus.mac_oe ? acc[7:0] : 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Result scoreboard and CLEAR-pulse counter.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.mac_reset === 1'b1) mrst_cnt++;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_result observed=0x%0h expected=none", bus.out_data);
            end else begin
                chk("result", 32'(bus.out_data), 32'(exp_q.pop_front()));
                results++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.w_wr_en   = 1'b1;
        bus.w_wr_addr = a;
        bus.w_wr_data = d;
        tick();
        bus.w_wr_en = 1'b0;
        wmodel[a] = d;
    endtask

    task automatic load_all(input logic [7:0] d);
        for (int i = 0; i < NI; i++) wr(4'(i), d);
    endtask

    task automatic start_vec();
        sum = 8'd0;
        idx = 0;
    endtask

    task automatic end_vec();
        exp_q.push_back(sum);
    endtask

    task automatic send_elem(input logic [7:0] d);
        bit got = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                got = 1'b1;
                last_hs = cyc;
                chk("hs_mac_in", 32'(bus.mac_in), 32'(d));
                chk("hs_mac_weight", 32'(bus.mac_weight), 32'(wmodel[idx]));
                sum = sum + wmodel[idx] * d;
                idx++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL handshake_timeout observed=no_in_ready expected=in_ready");
        end
    endtask

    // Waits for out_valid after the last element; checks DRAIN zeros, mac_oe and valid latency.
    task automatic wait_out();
        bit seen = 1'b0;
        int oe_c = -1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (cyc == last_hs + 1) chk("drain_mac_in", 32'(bus.mac_in), 32'd0);
            if (bus.mac_oe === 1'b1 && oe_c < 0) oe_c = cyc;
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
                chk("oe_latency", 32'(oe_c - last_hs), 32'd2);
                chk("valid_latency", 32'(cyc - last_hs), 32'd3);
            end
            tick();
        end
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL out_valid_timeout observed=0 expected=1");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;
        int m0;
        reset = 1'b1;
        bus.w_wr_en = 1'b0; bus.w_wr_addr = '0; bus.w_wr_data = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        tick(); tick();

        // Reset values
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mac_reset", 32'(bus.mac_reset), 32'd1);
        chk("rst_mac_oe", 32'(bus.mac_oe), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_mac_weight", 32'(bus.mac_weight), 32'd0);
        chk("rst_mac_in", 32'(bus.mac_in), 32'd0);
        chk("rst_mac_forget", 32'(bus.mac_forget), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("idle_mac_reset", 32'(bus.mac_reset), 32'd0);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
        tick();

        // Weights all 1, elements 1..16 back-to-back: 136
        load_all(8'd1);
        bus.out_ready = 1'b1;
        start_vec();
        for (int i = 1; i <= NI; i++) send_elem(8'(i));
        end_vec();
        wait_out();

        // Weights all 2, elements all 3 with a bubble after each: 0x60
        load_all(8'd2);
        start_vec();
        for (int i = 0; i < NI; i++) begin
            send_elem(8'd3);
            if (i < NI - 1) begin
                @(negedge clk);
                chk("bubble_mac_in", 32'(bus.mac_in), 32'd0);
                chk("bubble_mac_weight", 32'(bus.mac_weight), 32'd0);
                tick();
            end
        end
        end_vec();
        wait_out();

        // Result held with out_ready low, then released alongside in_valid
        bus.out_ready = 1'b0;
        start_vec();
        for (int i = 0; i < NI; i++) send_elem(8'(i));
        end_vec();
        held = sum;
        wait_out();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_out_data", 32'(bus.out_data), 32'(held));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_mac_oe", 32'(bus.mac_oe), 32'd0);
            chk("hold_mac_in", 32'(bus.mac_in), 32'd0);
            tick();
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("after_release_valid", 32'(bus.out_valid), 32'd0);
        tick();

        // Reset after 7 handshakes, then a full vector of 1s with weights 1: 16
        load_all(8'd1);
        start_vec();
        for (int i = 0; i < 7; i++) send_elem(8'd5);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_mac_reset", 32'(bus.mac_reset), 32'd1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_idle_mac_reset", 32'(bus.mac_reset), 32'd0);
        tick();
        start_vec();
        for (int i = 0; i < NI; i++) send_elem(8'd1);
        end_vec();
        wait_out();

        // Weight write during STREAM is dropped; then a second vector back-to-back
        m0 = mrst_cnt;
        start_vec();
        send_elem(8'd4);
        bus.w_wr_en = 1'b1; bus.w_wr_addr = 4'd0; bus.w_wr_data = 8'h7F;
        for (int i = 1; i < NI; i++) send_elem(8'd2);
        bus.w_wr_en = 1'b0;
        end_vec();
        wait_out();
        start_vec();
        for (int i = 0; i < NI; i++) send_elem(8'd3);
        end_vec();
        wait_out();
        chk("mac_reset_pulses", 32'(mrst_cnt - m0), 32'd2);

        tick(); tick();
        chk("results_seen", 32'(results), 32'd6);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
